// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register command sequencer.
// The opcode and sel encodings are identical, so a running op drives sel unchanged.
package shift_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [1:0] op_to_sel(input logic [1:0] op);
    logic [1:0] s;
    case (op)
      OP_SHR:  s = SEL_SHR;
      OP_SHL:  s = SEL_SHL;
      OP_LOAD: s = SEL_LOAD;
      default: s = SEL_HOLD;
    endcase
    return s;
  endfunction

  function automatic logic is_shift(input logic [1:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter that tracks the remaining shift cycles of a command.
// last_o flags the final drive cycle (count == 1).
module shift_seq_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Expands load/shift/hold commands into per-cycle drive for the 4-bit universal shift register.
// Optional rotate mode (cmd_rot, q_fb) is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             cmd_rot,
  input  logic [WIDTH-1:0] q_fb,
`endif
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] d,
  output logic             serial_in_left,
  output logic             serial_in_right,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             cnt_last;
  logic             left_bit;
  logic             right_bit;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rot_q, rot_d;
`endif

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  shift_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (cmd_cnt),
    .dec_i      ((state_q == ST_RUN) && is_shift(op_q)),
    .last_o     (cnt_last)
  );

  // Outputs are computed from the next state so they line up with it after the edge.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    fill_d  = fill_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          fill_d = cmd_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d  = cmd_rot;
`endif
          if ((cmd_op == OP_HOLD) || (is_shift(cmd_op) && (cmd_cnt == '0))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if ((op_q == OP_LOAD) || cnt_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    sel_d  = (state_d == ST_RUN) ? op_to_sel(op_d) : SEL_HOLD;
    dout_d = ((state_d == ST_RUN) && (op_d == OP_LOAD)) ? data_d : '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      data_q  <= '0;
      fill_q  <= 1'b0;
      sel_q   <= SEL_HOLD;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Rotation feeds the bit falling off the opposite end straight back in.
`ifdef SHIFT_SEQ_ROTATE_EN
  assign left_bit  = rot_q ? q_fb[WIDTH-1] : fill_q;
  assign right_bit = rot_q ? q_fb[0] : fill_q;
`else
  assign left_bit  = fill_q;
  assign right_bit = fill_q;
`endif

  assign serial_in_left  = (state_q == ST_RUN) && (op_q == OP_SHL) && left_bit;
  assign serial_in_right = (state_q == ST_RUN) && (op_q == OP_SHR) && right_bit;

  assign sel  = sel_q;
  assign d    = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl driving a behavioural 4-bit universal shift register.
// Rotate cases run only when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_cnt = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_fill = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic       cmd_rot = 1'b0;
`endif
  logic [1:0] sel;
  logic [3:0] d;
  logic       serial_in_left;
  logic       serial_in_right;
  logic       busy;
  logic       done;

  logic [3:0] qReg = 4'd0;
  logic [3:0] modelQ = 4'd0;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] d;
    logic       fill;
    logic       rot;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   edgeCnt = 0;
  int   acceptEdge = 0;
  int   lastDoneEdge = 0;
  int   driveSeen = 0;
  int   doneSeen = 0;
  bit   started = 1'b0;

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_cnt         (cmd_cnt),
    .cmd_data        (cmd_data),
    .cmd_fill        (cmd_fill),
`ifdef SHIFT_SEQ_ROTATE_EN
    .cmd_rot         (cmd_rot),
    .q_fb            (qReg),
`endif
    .sel             (sel),
    .d               (d),
    .serial_in_left  (serial_in_left),
    .serial_in_right (serial_in_right),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // The register the sequencer feeds; it has no reset of its own.
  always @(posedge clk) begin
    case (sel)
      2'b01:   qReg <= {serial_in_right, qReg[3:1]};
      2'b10:   qReg <= {qReg[2:0], serial_in_left};
      2'b11:   qReg <= d;
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edgeCnt);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out at edge %0d", name, edgeCnt);
  endtask

  // Issues one command and queues the cycle-by-cycle behaviour it must produce.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                               input logic fill, input logic rot);
    bit   ok;
    int   nDrive;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_rot   = rot;
`endif
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("accept_wait");
    @(posedge clk);
    #1;
    acceptEdge = edgeCnt;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_cnt   = 3'($urandom);
    cmd_data  = 4'($urandom);
    cmd_fill  = 1'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
    cmd_rot   = 1'($urandom);
`endif
    if (op == OP_LOAD) nDrive = 1;
    else if (op == OP_HOLD) nDrive = 0;
    else nDrive = int'(cnt);
    for (int i = 0; i < nDrive; i++) begin
      e.sel   = op;
      e.d     = (op == OP_LOAD) ? data : 4'd0;
      e.fill  = fill;
      e.rot   = rot;
      e.busy  = 1'b1;
      e.done  = 1'b0;
      e.ready = 1'b0;
      expQ.push_back(e);
    end
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("idle_wait");
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic expSil;
    logic expSir;
    if (started) begin
      checkOutput("q", 32'(qReg), 32'(modelQ));
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
      end else begin
        e = '0;
        e.ready = 1'b1;
      end
      expSil = (e.sel == OP_SHL) ? (e.rot ? modelQ[3] : e.fill) : 1'b0;
      expSir = (e.sel == OP_SHR) ? (e.rot ? modelQ[0] : e.fill) : 1'b0;
      checkOutput("sel", 32'(sel), 32'(e.sel));
      checkOutput("d", 32'(d), 32'(e.d));
      checkOutput("serial_in_left", 32'(serial_in_left), 32'(expSil));
      checkOutput("serial_in_right", 32'(serial_in_right), 32'(expSir));
      checkOutput("busy", 32'(busy), 32'(e.busy));
      checkOutput("done", 32'(done), 32'(e.done));
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(e.ready && !rst));
      case (e.sel)
        2'b01:   modelQ = {expSir, modelQ[3:1]};
        2'b10:   modelQ = {modelQ[2:0], expSil};
        2'b11:   modelQ = e.d;
        default: ;
      endcase
      if (sel != 2'b00) driveSeen++;
      if (done) begin
        doneSeen++;
        lastDoneEdge = edgeCnt;
      end
    end
  end

  initial begin
    int base;
    int firstAccept;
    rst = 1'b1;
    @(posedge clk);
    #1;
    started = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    base = driveSeen;
    applyStimulus(OP_LOAD, 3'd0, 4'b1010, 1'b0, 1'b0);
    waitIdle();
    checkOutput("load_q", 32'(qReg), 32'hA);
    checkOutput("load_drives", 32'(driveSeen - base), 32'd1);
    checkOutput("load_done_at", 32'(lastDoneEdge + 1 - acceptEdge), 32'd2);

    base = driveSeen;
    applyStimulus(OP_SHR, 3'd2, 4'b0101, 1'b1, 1'b0);
    waitIdle();
    checkOutput("shr2_q", 32'(qReg), 32'hE);
    checkOutput("shr2_drives", 32'(driveSeen - base), 32'd2);
    checkOutput("shr2_done_at", 32'(lastDoneEdge + 1 - acceptEdge), 32'd3);

    base = driveSeen;
    applyStimulus(OP_LOAD, 3'd5, 4'b1010, 1'b1, 1'b0);
    firstAccept = acceptEdge;
    applyStimulus(OP_SHL, 3'd3, 4'b1111, 1'b0, 1'b0);
    checkOutput("b2b_spacing", 32'(acceptEdge - firstAccept), 32'd3);
    waitIdle();
    checkOutput("shl3_q", 32'(qReg), 32'h0);
    checkOutput("shl3_drives", 32'(driveSeen - base), 32'd4);
    checkOutput("shl3_done_at", 32'(lastDoneEdge + 1 - acceptEdge), 32'd4);

    applyStimulus(OP_LOAD, 3'd0, 4'b0101, 1'b0, 1'b0);
    waitIdle();
    base = driveSeen;
    applyStimulus(OP_HOLD, 3'd6, 4'b1111, 1'b1, 1'b0);
    waitIdle();
    checkOutput("hold_done_at", 32'(lastDoneEdge + 1 - acceptEdge), 32'd1);
    applyStimulus(OP_SHL, 3'd0, 4'b1111, 1'b1, 1'b0);
    waitIdle();
    checkOutput("shl0_done_at", 32'(lastDoneEdge + 1 - acceptEdge), 32'd1);
    checkOutput("hold_drives", 32'(driveSeen - base), 32'd0);
    checkOutput("hold_q", 32'(qReg), 32'h5);

    applyStimulus(OP_LOAD, 3'd0, 4'b0000, 1'b0, 1'b0);
    waitIdle();
    base = doneSeen;
    applyStimulus(OP_SHR, 3'd7, 4'b0000, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expQ.delete();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_sel", 32'(sel), 32'd0);
    checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(doneSeen - base), 32'd0);
    checkOutput("abort_q", 32'(qReg), 32'hF);

    applyStimulus(OP_SHR, 3'd1, 4'b0000, 1'b0, 1'b0);
    waitIdle();
    checkOutput("recover_q", 32'(qReg), 32'h7);

`ifdef SHIFT_SEQ_ROTATE_EN
    applyStimulus(OP_LOAD, 3'd0, 4'b1000, 1'b0, 1'b0);
    applyStimulus(OP_SHL, 3'd1, 4'b0000, 1'b0, 1'b1);
    waitIdle();
    checkOutput("rot_shl1_q", 32'(qReg), 32'h1);
    applyStimulus(OP_SHL, 3'd4, 4'b0000, 1'b0, 1'b1);
    waitIdle();
    checkOutput("rot_shl4_q", 32'(qReg), 32'h1);
    applyStimulus(OP_SHR, 3'd1, 4'b0000, 1'b0, 1'b1);
    waitIdle();
    checkOutput("rot_shr1_q", 32'(qReg), 32'h8);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
